// File: rtl/battleship_fsm.sv
// Game sequencer for two-board Battleship: ship loading, alternating attack turns,
// attack validation and win detection, with Moore outputs decoded from the state register.
module battleship_fsm (
  input  logic       clk,
  input  logic       clr,
  input  logic       BTN1,
  input  logic       BTN2A,
  input  logic       BTN2B,
  input  logic       LivA,
  input  logic       LivB,
  input  logic       OKA,
  input  logic       OKB,
  output logic       ST,
  output logic       LDR1A,
  output logic       LDR1B,
  output logic       LDR2A,
  output logic       LDR2B,
  output logic [2:0] DispA,
  output logic [2:0] DispB
);

  typedef enum logic [3:0] {
    S_LOAD    = 4'd0,
    S_A_TURN  = 4'd1,
    S_A_FIRE  = 4'd2,
    S_A_CHECK = 4'd3,
    S_A_BAD   = 4'd4,
    S_A_EVAL  = 4'd5,
    S_B_TURN  = 4'd6,
    S_B_FIRE  = 4'd7,
    S_B_CHECK = 4'd8,
    S_B_BAD   = 4'd9,
    S_B_EVAL  = 4'd10,
    S_A_WINS  = 4'd11,
    S_B_WINS  = 4'd12
  } state_t;

  localparam logic [2:0] D_LOAD = 3'd0;
  localparam logic [2:0] D_FIRE = 3'd1;
  localparam logic [2:0] D_WAIT = 3'd2;
  localparam logic [2:0] D_ERR  = 3'd3;
  localparam logic [2:0] D_WIN  = 3'd4;
  localparam logic [2:0] D_LOSE = 3'd5;

  state_t state, state_nxt;
  logic   btn2a_p1, btn2b_p1;
  logic   rise_a, rise_b;

  // Button copies track every cycle, so an off-turn press never leaves a pending edge.
  assign rise_a = BTN2A & ~btn2a_p1;
  assign rise_b = BTN2B & ~btn2b_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_LOAD;
      btn2a_p1 <= 1'b0;
      btn2b_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn2a_p1 <= BTN2A;
      btn2b_p1 <= BTN2B;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD:    if (BTN1) state_nxt = S_A_TURN;
      S_A_TURN:  if (rise_a) state_nxt = S_A_FIRE;
      S_A_FIRE:  state_nxt = S_A_CHECK;
      S_A_CHECK: state_nxt = OKB ? S_A_EVAL : S_A_BAD;
      S_A_BAD:   if (rise_a) state_nxt = S_A_FIRE;
      S_A_EVAL:  state_nxt = LivB ? S_B_TURN : S_A_WINS;
      S_B_TURN:  if (rise_b) state_nxt = S_B_FIRE;
      S_B_FIRE:  state_nxt = S_B_CHECK;
      S_B_CHECK: state_nxt = OKA ? S_B_EVAL : S_B_BAD;
      S_B_BAD:   if (rise_b) state_nxt = S_B_FIRE;
      S_B_EVAL:  state_nxt = LivA ? S_A_TURN : S_B_WINS;
      S_A_WINS:  state_nxt = S_A_WINS;
      S_B_WINS:  state_nxt = S_B_WINS;
      default:   state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    ST    = 1'b1;
    LDR1A = 1'b0;
    LDR1B = 1'b0;
    LDR2A = 1'b0;
    LDR2B = 1'b0;
    DispA = D_WAIT;
    DispB = D_WAIT;
    unique case (state)
      S_LOAD: begin
        ST    = 1'b0;
        LDR1A = 1'b1;
        LDR1B = 1'b1;
        DispA = D_LOAD;
        DispB = D_LOAD;
      end
      S_A_TURN: DispA = D_FIRE;
      S_A_FIRE: LDR2A = 1'b1;
      S_A_BAD:  DispA = D_ERR;
      S_B_TURN: DispB = D_FIRE;
      S_B_FIRE: LDR2B = 1'b1;
      S_B_BAD:  DispB = D_ERR;
      S_A_WINS: begin
        DispA = D_WIN;
        DispB = D_LOSE;
      end
      S_B_WINS: begin
        DispA = D_LOSE;
        DispB = D_WIN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_battleship_fsm.sv
// Self-checking bench for battleship_fsm: directed scenarios plus random play,
// compared every cycle against a turn/phase-level game model.
module tb_battleship_fsm;

  logic       clk = 1'b0;
  logic       clr, BTN1, BTN2A, BTN2B, LivA, LivB, OKA, OKB;
  logic       ST, LDR1A, LDR1B, LDR2A, LDR2B;
  logic [2:0] DispA, DispB;

  int total = 0;
  int bad = 0;

  battleship_fsm dut (
    .clk(clk), .clr(clr), .BTN1(BTN1), .BTN2A(BTN2A), .BTN2B(BTN2B),
    .LivA(LivA), .LivB(LivB), .OKA(OKA), .OKB(OKB),
    .ST(ST), .LDR1A(LDR1A), .LDR1B(LDR1B), .LDR2A(LDR2A), .LDR2B(LDR2B),
    .DispA(DispA), .DispB(DispB)
  );

  always #5 clk = ~clk;

  // Game model: loading flag, winner, whose turn, shot progress and error flag.
  int m_loading = 1;
  int m_winner  = -1;
  int m_turn    = 0;
  int m_pending = 0;   // 3 = strobe cycle, 2 = validation, 1 = hit evaluation, 0 = idle
  int m_err     = 0;
  bit m_prev [2] = '{1'b0, 1'b0};

  localparam logic [10:0] OUT_LOAD = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [2:0] da, db;
    logic       l2a, l2b;
    if (m_loading != 0) return OUT_LOAD;
    l2a = 1'b0; l2b = 1'b0; da = 3'd2; db = 3'd2;
    if (m_winner >= 0) begin
      da = (m_winner == 0) ? 3'd4 : 3'd5;
      db = (m_winner == 1) ? 3'd4 : 3'd5;
    end else if (m_pending == 3) begin
      l2a = (m_turn == 0);
      l2b = (m_turn == 1);
    end else if (m_pending == 0) begin
      if (m_turn == 0) da = (m_err != 0) ? 3'd3 : 3'd1;
      else             db = (m_err != 0) ? 3'd3 : 3'd1;
    end
    return {1'b1, 1'b0, 1'b0, l2a, l2b, da, db};
  endfunction

  task automatic model_tick();
    bit btn [2];
    bit ok [2];
    bit live [2];
    btn[0] = BTN2A; btn[1] = BTN2B;
    ok[0] = OKB;    ok[1] = OKA;     // validity of each player's own attack
    live[0] = LivA; live[1] = LivB;
    if (clr) begin
      m_loading = 1; m_winner = -1; m_pending = 0; m_err = 0; m_turn = 0;
      m_prev[0] = 1'b0; m_prev[1] = 1'b0;
      return;
    end
    if (m_loading != 0) begin
      if (BTN1) begin m_loading = 0; m_turn = 0; m_err = 0; m_pending = 0; end
    end else if (m_winner >= 0) begin
    end else if (m_pending == 3) begin
      m_pending = 2;
    end else if (m_pending == 2) begin
      if (ok[m_turn]) m_pending = 1;
      else begin m_pending = 0; m_err = 1; end
    end else if (m_pending == 1) begin
      m_pending = 0;
      if (!live[1 - m_turn]) m_winner = m_turn;
      else begin m_turn = 1 - m_turn; m_err = 0; end
    end else if (btn[m_turn] && !m_prev[m_turn]) begin
      m_pending = 3;
      m_err = 0;
    end
    m_prev[0] = btn[0];
    m_prev[1] = btn[1];
  endtask

  int cnt_l2a, cnt_l2b;

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check("outputs", {ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB}, model_out());
    cnt_l2a += LDR2A;
    cnt_l2b += LDR2B;
  endtask

  function automatic logic [10:0] cur();
    return {ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB};
  endfunction

  task automatic fire_a(input int extra);
    BTN2A = 1'b1; step(); BTN2A = 1'b0;
    repeat (extra) step();
  endtask

  task automatic fire_b(input int extra);
    BTN2B = 1'b1; step(); BTN2B = 1'b0;
    repeat (extra) step();
  endtask

  initial begin
    clr = 1'b1; BTN1 = 1'b0; BTN2A = 1'b0; BTN2B = 1'b0;
    LivA = 1'b1; LivB = 1'b1; OKA = 1'b1; OKB = 1'b1;
    cnt_l2a = 0; cnt_l2b = 0;
    step();
    check("reset_outputs", cur(), OUT_LOAD);
    clr = 1'b0;

    BTN2A = 1'b1;
    repeat (5) step();
    check("load_ignores_fire", cur(), OUT_LOAD);
    BTN2A = 1'b0;

    BTN1 = 1'b1; step(); BTN1 = 1'b0;
    check("a_turn_entry", cur(), {1'b1, 4'b0000, 3'd1, 3'd2});

    cnt_l2a = 0;
    fire_a(3);
    check("a_fire_one_pulse", cnt_l2a, 1);
    check("b_turn_after_3", cur(), {1'b1, 4'b0000, 3'd2, 3'd1});
    fire_b(3);
    check("back_to_a", cur(), {1'b1, 4'b0000, 3'd1, 3'd2});

    OKB = 1'b0; cnt_l2a = 0;
    fire_a(4);
    check("a_invalid_err", cur(), {1'b1, 4'b0000, 3'd3, 3'd2});
    check("a_invalid_no_repulse", cnt_l2a, 1);
    OKB = 1'b1;
    fire_a(3);
    check("a_retry_b_turn", cur(), {1'b1, 4'b0000, 3'd2, 3'd1});
    fire_b(3);

    cnt_l2a = 0; BTN2A = 1'b1;
    repeat (20) step();
    BTN2A = 1'b0;
    check("held_one_pulse", cnt_l2a, 1);
    fire_b(3);
    cnt_l2b = 0; BTN2B = 1'b1;
    repeat (3) step();
    BTN2B = 1'b0;
    check("b_off_turn_ignored", cnt_l2b, 0);
    fire_a(6);
    check("b_not_armed", cur(), {1'b1, 4'b0000, 3'd2, 3'd1});

    LivA = 1'b0;
    fire_b(3);
    check("b_wins", cur(), {1'b1, 4'b0000, 3'd5, 3'd4});
    for (int i = 0; i < 10; i++) begin
      BTN2A = 1'($urandom); BTN2B = 1'($urandom); BTN1 = 1'($urandom);
      step();
    end
    check("b_wins_held", cur(), {1'b1, 4'b0000, 3'd5, 3'd4});
    BTN2A = 1'b0; BTN2B = 1'b0; BTN1 = 1'b0; LivA = 1'b1;
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_from_win", cur(), OUT_LOAD);

    BTN1 = 1'b1; step(); BTN1 = 1'b0;
    BTN2A = 1'b1; step();
    check("in_a_fire", LDR2A, 1'b1);
    clr = 1'b1; step(); clr = 1'b0; BTN2A = 1'b0;
    check("clr_mid_fire", cur(), OUT_LOAD);

    for (int i = 0; i < 4000; i++) begin
      clr  = ($urandom_range(0, 299) == 0);
      BTN1 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) BTN2A = ~BTN2A;
      if ($urandom_range(0, 3) == 0) BTN2B = ~BTN2B;
      OKA  = ($urandom_range(0, 3) != 0);
      OKB  = ($urandom_range(0, 3) != 0);
      LivA = ($urandom_range(0, 9) != 0);
      LivB = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
